sram_uart_tx_interface: RTL and testbench

- Transmit-side counterpart of the UART-to-SRAM receive path: streams a block of 16-bit SRAM words out on the UART TX pin, two bytes per word.
- Reads the SRAM through the shared SRAM_controller port. The top level muxes this port in during a new top-level transmit state.
- Used to dump decoded RGB/YUV images back to the host for checking against golden files.
- Word fetch and byte serialisation overlap, so frames leave back-to-back with no idle bits between them.

---
 rtl/sram_uart_tx_interface_pkg.sv | 29 ++
 rtl/sram_uart_tx_interface_serializer.sv | 90 +++++++++
 rtl/sram_uart_tx_interface.sv | 139 +++++++++++++
 tb/tb_sram_uart_tx_interface.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_uart_tx_interface_pkg.sv
// Shared types and constants for the SRAM-to-UART transmit path.
// Holds both FSM state encodings and the default baud divisor.
package sram_uart_tx_interface_pkg;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_ISSUE,
    S_TX_WAIT1,
    S_TX_WAIT2,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_FINISH
  } sram_tx_state_type;

  typedef enum logic [1:0] {
    S_UTX_IDLE,
    S_UTX_START,
    S_UTX_DATA,
    S_UTX_STOP
  } uart_tx_state_type;

  localparam int UART_CLOCKS_PER_BIT_DEFAULT = 434;

  // Width of a down-counter that must hold clocks_per_bit-1.
  function automatic int period_cnt_width(input int clocks_per_bit);
    return (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/sram_uart_tx_interface_serializer.sv
// 8N1 UART byte serializer; ready in idle and in the last stop-bit cycle,
// so a load in that cycle starts the next frame with no idle gap.
//
// state        | meaning
// S_UTX_IDLE   | line high, waiting for a byte
// S_UTX_START  | driving the start bit (0)
// S_UTX_DATA   | shifting 8 data bits, LSB first
// S_UTX_STOP   | driving the stop bit (1)
module uart_tx_serializer
  import sram_uart_tx_interface_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_uart_tx
);

  localparam int CW = period_cnt_width(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(CLOCKS_PER_BIT - 1);

  uart_tx_state_type r_state, w_state_next;
  logic [CW-1:0] r_period_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_period_done, w_ready, w_load;

  always_comb begin
    w_period_done = (r_period_cnt == '0);
    w_ready       = (r_state == S_UTX_IDLE) || ((r_state == S_UTX_STOP) && w_period_done);
    w_load        = i_tx_start && w_ready;
    w_state_next  = r_state;
    case (r_state)
      S_UTX_IDLE:  w_state_next = S_UTX_IDLE;
      S_UTX_START: if (w_period_done) w_state_next = S_UTX_DATA;
      S_UTX_DATA:  if (w_period_done && (r_bit_cnt == 3'd0)) w_state_next = S_UTX_STOP;
      S_UTX_STOP:  if (w_period_done) w_state_next = S_UTX_IDLE;
      default:     w_state_next = S_UTX_IDLE;
    endcase
    if (w_load) w_state_next = S_UTX_START;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_UTX_IDLE;
      r_period_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_shift      <= i_tx_data;
        r_period_cnt <= PERIOD_LAST;
        r_tx         <= 1'b0;
      end else if (r_state != S_UTX_IDLE) begin
        if (!w_period_done) begin
          r_period_cnt <= r_period_cnt - CW'(1);
        end else begin
          r_period_cnt <= PERIOD_LAST;
          case (r_state)
            S_UTX_START: begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= 3'd7;
            end
            S_UTX_DATA: begin
              if (r_bit_cnt == 3'd0) begin
                r_tx <= 1'b1;
              end else begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt - 3'd1;
              end
            end
            default: r_tx <= 1'b1;
          endcase
        end
      end
    end
  end

  assign o_tx_ready = w_ready;
  assign o_uart_tx  = r_tx;

endmodule

// File: rtl/sram_uart_tx_interface.sv
// Streams a block of 16-bit SRAM words out on UART TX, high byte first,
// prefetching the next word while the current low byte is on the line.
//
// state         | meaning
// S_TX_IDLE     | waiting for Start
// S_TX_ISSUE    | first read address on the SRAM port
// S_TX_WAIT1    | SRAM read latency, cycle 1
// S_TX_WAIT2    | SRAM read latency, cycle 2; word captured
// S_TX_SEND_HI  | hand word[15:8] to the serializer
// S_TX_SEND_LO  | hand word[7:0] to the serializer; prefetch next word
// S_TX_FINISH   | drain the last frame, then pulse Done
module sram_uart_tx_interface
  import sram_uart_tx_interface_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT,
  parameter int ADDR_WIDTH     = 18
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_address,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  output logic [ADDR_WIDTH-1:0] o_sram_address,
  input  logic [15:0]           i_sram_read_data,
  output logic                  o_sram_we_n,
  output logic                  o_uart_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  sram_tx_state_type r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_words_left;
  logic [15:0]           r_buffer;
  logic                  r_buffer_valid, r_done;
  logic [2:0]            r_pf_pipe;
  logic                  w_accept, w_capture, w_tx_start, w_tx_ready;
  logic                  w_load_lo, w_prefetch, w_done_set;
  logic [7:0]            w_tx_data;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_tx_start   = 1'b0;
    w_tx_data    = r_buffer[15:8];
    w_load_lo    = 1'b0;
    w_prefetch   = 1'b0;
    w_done_set   = 1'b0;
    // Prefetch data lands two cycles after its address, same as the first read.
    w_capture    = (r_state == S_TX_WAIT2) || r_pf_pipe[2];
    case (r_state)
      S_TX_IDLE: begin
        if (i_start) begin
          if (i_word_count != '0) begin
            w_accept     = 1'b1;
            w_state_next = S_TX_ISSUE;
          end else begin
            w_done_set = 1'b1;
          end
        end
      end
      S_TX_ISSUE: w_state_next = S_TX_WAIT1;
      S_TX_WAIT1: w_state_next = S_TX_WAIT2;
      S_TX_WAIT2: w_state_next = S_TX_SEND_HI;
      S_TX_SEND_HI: begin
        if (r_buffer_valid) begin
          w_tx_start = 1'b1;
          if (w_tx_ready) w_state_next = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        w_tx_start = 1'b1;
        w_tx_data  = r_buffer[7:0];
        if (w_tx_ready) begin
          w_load_lo = 1'b1;
          if (r_words_left == ADDR_WIDTH'(1)) begin
            w_state_next = S_TX_FINISH;
          end else begin
            w_prefetch   = 1'b1;
            w_state_next = S_TX_SEND_HI;
          end
        end
      end
      S_TX_FINISH: begin
        if (w_tx_ready) begin
          w_done_set   = 1'b1;
          w_state_next = S_TX_IDLE;
        end
      end
      default: w_state_next = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_TX_IDLE;
      r_addr         <= '0;
      r_words_left   <= '0;
      r_buffer       <= '0;
      r_buffer_valid <= 1'b0;
      r_pf_pipe      <= '0;
      r_done         <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_done    <= w_done_set;
      r_pf_pipe <= {r_pf_pipe[1:0], w_prefetch};
      if (w_accept) begin
        r_addr       <= i_start_address;
        r_words_left <= i_word_count;
      end
      if (w_prefetch) begin
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_words_left <= r_words_left - ADDR_WIDTH'(1);
      end
      if (w_capture) begin
        r_buffer       <= i_sram_read_data;
        r_buffer_valid <= 1'b1;
      end else if (w_load_lo) begin
        r_buffer_valid <= 1'b0;
      end
    end
  end

  uart_tx_serializer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_serializer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_tx_start(w_tx_start),
    .i_tx_data (w_tx_data),
    .o_tx_ready(w_tx_ready),
    .o_uart_tx (o_uart_tx)
  );

  assign o_sram_address = r_addr;
  assign o_sram_we_n    = 1'b1;
  assign o_busy         = (r_state != S_TX_IDLE);
  assign o_done         = r_done;

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Scoreboard bench: stimulus queues expected bytes (with start cycle) and Done
// cycles; a UART decoder and a Done monitor pop and compare independently.
module tb_sram_uart_tx_interface;

  localparam int CPB_A = 4;
  localparam int CPB_B = 434;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, start_a, start_b;
  logic [17:0] addr_a, cnt_a, addr_b, cnt_b;
  logic [17:0] sram_addr_a, sram_addr_b;
  logic [15:0] rd_a, rd_a_d1, rd_b, rd_b_d1;
  logic        we_n_a, we_n_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [15:0] mem [0:262143];
  exp_t        exp_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_uart_tx_interface #(.CLOCKS_PER_BIT(CPB_A), .ADDR_WIDTH(18)) dut_a (
    .i_clock(clk), .i_reset(rst_a), .i_start(start_a),
    .i_start_address(addr_a), .i_word_count(cnt_a),
    .o_sram_address(sram_addr_a), .i_sram_read_data(rd_a),
    .o_sram_we_n(we_n_a), .o_uart_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );

  sram_uart_tx_interface #(.CLOCKS_PER_BIT(CPB_B), .ADDR_WIDTH(18)) dut_b (
    .i_clock(clk), .i_reset(rst_b), .i_start(start_b),
    .i_start_address(addr_b), .i_word_count(cnt_b),
    .o_sram_address(sram_addr_b), .i_sram_read_data(rd_b),
    .o_sram_we_n(we_n_b), .o_uart_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );

  // SRAM model: data valid two cycles after the address.
  always @(posedge clk) begin
    rd_a_d1 <= mem[sram_addr_a];
    rd_a    <= rd_a_d1;
    rd_b_d1 <= mem[sram_addr_b];
    rd_b    <= rd_b_d1;
  end

  function automatic void chk(input string name, input int got, input int exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void extra(input string name, input int got);
    n_total++;
    $display("FAIL %s: unexpected event, value %0h, expected none (cycle %0d)", name, got, cyc);
  endfunction

  // UART decoder for dut_a
  bit         in_frame = 1'b0;
  int         fstart, off;
  logic [7:0] rx_byte;
  exp_t       e;

  always @(negedge clk) begin
    if (rst_a) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_a === 1'b0) begin
        in_frame = 1'b1;
        fstart   = cyc;
      end
    end else begin
      off = cyc - fstart;
      if (off % CPB_A == CPB_A / 2) begin
        case (off / CPB_A)
          0: chk("start_bit", int'(tx_a), 0);
          9: begin
            chk("stop_bit", int'(tx_a), 1);
            if (exp_q.size() == 0) begin
              extra("frame", int'(rx_byte));
            end else begin
              e = exp_q.pop_front();
              chk("rx_byte", int'(rx_byte), int'(e.b));
              chk("frame_start_cycle", fstart, e.t);
            end
            in_frame = 1'b0;
          end
          default: rx_byte[3'(off / CPB_A - 1)] = tx_a;
        endcase
      end
    end
  end

  // Done monitor for dut_a
  int exp_done;
  always @(negedge clk) begin
    if (!rst_a && done_a === 1'b1) begin
      if (done_q.size() == 0) extra("done", cyc);
      else begin
        exp_done = done_q.pop_front();
        chk("done_cycle", cyc, exp_done);
      end
    end
  end

  // Line-transition monitor for dut_b
  bit   baud_arm = 1'b0;
  logic prev_b = 1'b1;
  int   n_tr = 0;
  int   first_tr, last_tr;
  always @(negedge clk) begin
    if (baud_arm && !rst_b && tx_b !== prev_b) begin
      n_tr++;
      if (n_tr == 1) first_tr = cyc;
      else chk("baud_gap", cyc - last_tr, CPB_B);
      last_tr = cyc;
    end
    prev_b = tx_b;
  end

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic issue(input logic [17:0] a, input logic [17:0] n, input bit accept,
                       output int c);
    logic [17:0] wa;
    logic [15:0] w;
    @(posedge clk); #1;
    c       = cyc;
    addr_a  = a;
    cnt_a   = n;
    start_a = 1'b1;
    if (accept) begin
      for (int i = 0; i < int'(n); i++) begin
        wa = a + 18'(i);
        w  = mem[wa];
        exp_q.push_back('{b: w[15:8], t: c + 5 + 20 * CPB_A * i});
        exp_q.push_back('{b: w[7:0],  t: c + 5 + 20 * CPB_A * i + 10 * CPB_A});
      end
      done_q.push_back((n == 0) ? c + 1 : c + 5 + 20 * int'(n) * CPB_A);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0) break;
    end
    chk("drain_timeout", exp_q.size() + done_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c, cx, cb;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    addr_a = '0; cnt_a = '0; addr_b = '0; cnt_b = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'hEEEE;
    mem[18'h00100] = 16'hA55A;
    mem[18'h00010] = 16'h0102;
    mem[18'h00011] = 16'h0304;
    mem[18'h00012] = 16'h0506;
    mem[18'h3FFFF] = 16'h1122;
    mem[18'h00000] = 16'h3344;
    mem[18'h00020] = 16'hBEEF;
    mem[18'h00021] = 16'hCAFE;
    mem[18'h00200] = 16'h3CC3;
    mem[18'h00300] = 16'h5555;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("reset_tx", int'(tx_a), 1);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_addr", int'(sram_addr_a), 0);
    chk("reset_we_n", int'(we_n_a), 1);
    chk("reset_tx_b", int'(tx_b), 1);

    // single word
    issue(18'h00100, 18'd1, 1'b1, c);
    at_cycle(c + 1);
    chk("single_busy_c1", int'(busy_a), 1);
    chk("single_addr_c1", int'(sram_addr_a), 'h100);
    at_cycle(c + 4);
    chk("single_tx_c4", int'(tx_a), 1);
    at_cycle(c + 84);
    chk("single_busy_c84", int'(busy_a), 1);
    at_cycle(c + 85);
    chk("single_busy_c85", int'(busy_a), 0);
    wait_quiet(50);

    // back-to-back streaming
    issue(18'h00010, 18'd3, 1'b1, c);
    wait_quiet(400);

    // zero length
    issue(18'h00050, 18'd0, 1'b1, c);
    at_cycle(c + 1);
    chk("zero_busy_c1", int'(busy_a), 0);
    chk("zero_tx_c1", int'(tx_a), 1);
    at_cycle(c + 2);
    chk("zero_busy_c2", int'(busy_a), 0);
    wait_quiet(20);

    // address wrap
    issue(18'h3FFFF, 18'd2, 1'b1, c);
    wait_quiet(300);

    // Start while busy is ignored
    issue(18'h00020, 18'd2, 1'b1, c);
    at_cycle(c + 30);
    issue(18'h00010, 18'd3, 1'b0, cx);
    wait_quiet(300);

    // reset during data bits of the second byte
    issue(18'h00100, 18'd1, 1'b1, c);
    at_cycle(c + 54);
    @(posedge clk); #1;
    rst_a = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("rst_mid_tx", int'(tx_a), 1);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_done", int'(done_a), 0);
    issue(18'h00200, 18'd1, 1'b1, c);
    wait_quiet(200);

    // default baud rate, word 0x5555: every bit boundary is a transition
    @(posedge clk); #1;
    baud_arm = 1'b1;
    cb       = cyc;
    addr_b   = 18'h00300;
    cnt_b    = 18'd1;
    start_b  = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    at_cycle(cb + 5 + 20 * CPB_B - 1);
    chk("baud_done_early", int'(done_b), 0);
    chk("baud_busy_last", int'(busy_b), 1);
    at_cycle(cb + 5 + 20 * CPB_B);
    chk("baud_done", int'(done_b), 1);
    repeat (3) @(negedge clk);
    chk("baud_edges", n_tr, 20);
    chk("baud_first_edge", first_tr, cb + 5);
    chk("we_n_a", int'(we_n_a), 1);
    chk("we_n_b", int'(we_n_b), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
